// File: rtl/rs_queue.sv
// rs_queue: multi-entry reservation station between dispatch and one FU.
// Entries capture missing operands from the CDB (including the op being
// dispatched this cycle) and one ready entry is issued per cycle over a
// valid/ready handshake.
// Optional feature: define RS_OLDEST_FIRST_EN to select the oldest ready entry
// through an age matrix; otherwise the lowest-index ready entry is selected.

// Per-entry storage: payload, source tags, readiness and captured values.
module rs_entry #(
  parameter int NSRC = 2,
  parameter int DW   = 8,
  parameter int OPW  = 8,
  parameter int TW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc,
  input  logic               free,
  input  logic               flush,
  input  logic [OPW-1:0]     op_in,
  input  logic [DW-1:0]      wbs_in,
  input  logic [DW-1:0]      flag_in,
  input  logic [TW-1:0]      robid_in,
  input  logic [NSRC*TW-1:0] srcids_in,
  input  logic [NSRC-1:0]    srcrdy_in,
  input  logic [NSRC*DW-1:0] srcvals_in,
  input  logic               cdbvalid,
  input  logic [TW-1:0]      cdbtag,
  input  logic [DW-1:0]      cdbval,
  output logic               valid,
  output logic               ready,
  output logic [OPW-1:0]     op,
  output logic [DW-1:0]      wbs,
  output logic [DW-1:0]      flag,
  output logic [TW-1:0]      robid,
  output logic [NSRC*DW-1:0] srcvals
);
  logic [NSRC-1:0]          rdy_q;
  logic [NSRC-1:0][TW-1:0]  id_q;
  logic [NSRC-1:0][DW-1:0]  val_q;

  assign srcvals = val_q;
  assign ready   = valid & (&rdy_q);

  // Allocation loads the op (with same-cycle CDB bypass); otherwise wake up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      op    <= '0;
      wbs   <= '0;
      flag  <= '0;
      robid <= '0;
      rdy_q <= '0;
      id_q  <= '0;
      val_q <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (alloc) begin
      valid <= 1'b1;
      op    <= op_in;
      wbs   <= wbs_in;
      flag  <= flag_in;
      robid <= robid_in;
      for (int i = 0; i < NSRC; i++) begin
        id_q[i] <= srcids_in[i*TW +: TW];
        if (srcrdy_in[i]) begin
          rdy_q[i] <= 1'b1;
          val_q[i] <= srcvals_in[i*DW +: DW];
        end else if (cdbvalid && srcids_in[i*TW +: TW] == cdbtag) begin
          rdy_q[i] <= 1'b1;
          val_q[i] <= cdbval;
        end else begin
          rdy_q[i] <= 1'b0;
          val_q[i] <= '0;
        end
      end
    end else begin
      if (free) valid <= 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        if (valid && !rdy_q[i] && cdbvalid && id_q[i] == cdbtag) begin
          rdy_q[i] <= 1'b1;
          val_q[i] <= cdbval;
        end
      end
    end
  end
endmodule

module rs_queue #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 2,
  parameter int DW    = 8,
  parameter int OPW   = 8,
  parameter int TW    = 4,
  localparam int CW   = $clog2(DEPTH+1),
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dispvalid,
  output logic               dispready,
  input  logic [OPW-1:0]     operandin,
  input  logic [DW-1:0]      wbsin,
  input  logic [DW-1:0]      flagin,
  input  logic [TW-1:0]      robidin,
  input  logic [NSRC*TW-1:0] srcidsin,
  input  logic [NSRC-1:0]    srcrdyin,
  input  logic [NSRC*DW-1:0] srcvalsin,
  input  logic               cdbvalid,
  input  logic [TW-1:0]      cdbtag,
  input  logic [DW-1:0]      cdbval,
  output logic               issuevalid,
  input  logic               issueready,
  output logic [OPW-1:0]     operandout,
  output logic [DW-1:0]      wbsout,
  output logic [NSRC*DW-1:0] srcvalsout,
  output logic [DW-1:0]      flagout,
  output logic [TW-1:0]      robidout,
  input  logic               flush,
  output logic [CW-1:0]      count
);
  logic [DEPTH-1:0]                ent_v, ent_rdy, alloc_oh, free_oh;
  logic [DEPTH-1:0][OPW-1:0]       ent_op;
  logic [DEPTH-1:0][DW-1:0]        ent_wbs, ent_flag;
  logic [DEPTH-1:0][TW-1:0]        ent_rob;
  logic [DEPTH-1:0][NSRC*DW-1:0]   ent_sv;
  logic                            disp_fire, issue_fire, alloc_found;
  logic                            pick_any, sel_any, lock_q;
  logic [IW-1:0]                   pick_idx, sel_idx, lock_idx_q;

  assign disp_fire  = dispvalid & dispready & ~flush;
  assign issue_fire = issuevalid & issueready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_entry #(.NSRC(NSRC), .DW(DW), .OPW(OPW), .TW(TW)) u_ent (
      .clk, .rst,
      .alloc(alloc_oh[g]), .free(free_oh[g]), .flush,
      .op_in(operandin), .wbs_in(wbsin), .flag_in(flagin), .robid_in(robidin),
      .srcids_in(srcidsin), .srcrdy_in(srcrdyin), .srcvals_in(srcvalsin),
      .cdbvalid, .cdbtag, .cdbval,
      .valid(ent_v[g]), .ready(ent_rdy[g]), .op(ent_op[g]), .wbs(ent_wbs[g]),
      .flag(ent_flag[g]), .robid(ent_rob[g]), .srcvals(ent_sv[g])
    );
  end

  // Occupancy is the population count of valid entries.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(ent_v[i]);
  end

  // Slots freed by this cycle's issue are still valid here, so not reused yet.
  assign dispready = (count < CW'(DEPTH));

  // Allocate the lowest-index free entry.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_v[i] && !alloc_found) begin
        alloc_oh[i] = disp_fire;
        alloc_found = 1'b1;
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // age_q[r][c]=1: entry r is older than entry c.
  logic [DEPTH-1:0][DEPTH-1:0] age_q;
  logic                        older;

  // A new entry is younger than everything currently held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc_oh[k]) begin
          for (int r = 0; r < DEPTH; r++) begin
            age_q[k][r] <= 1'b0;
            if (r != k) age_q[r][k] <= 1'b1;
          end
        end
      end
    end
  end

  // Oldest candidate: no other candidate is older than it.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    older    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      older = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ent_rdy[j] && age_q[j][i]) older = 1'b1;
      if (ent_rdy[i] && !older) begin
        pick_any = 1'b1;
        pick_idx = IW'(i);
      end
    end
  end
`else
  // Lowest-index candidate wins (scan downward so the last hit is lowest).
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        pick_any = 1'b1;
        pick_idx = IW'(i);
      end
    end
  end
`endif

  // A stalled presentation stays locked so the FU sees a stable op.
  always_comb begin
    sel_idx = lock_q ? lock_idx_q : pick_idx;
    sel_any = lock_q ? ent_rdy[lock_idx_q] : pick_any;
  end

  assign issuevalid = sel_any & ~flush;

  // Remember the presented entry while the FU back-pressures.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= issuevalid & ~issueready;
      lock_idx_q <= sel_idx;
    end
  end

  // Release the issued entry; drive zeros when nothing is presented.
  always_comb begin
    free_oh    = '0;
    operandout = '0;
    wbsout     = '0;
    flagout    = '0;
    robidout   = '0;
    srcvalsout = '0;
    if (issuevalid) begin
      free_oh[sel_idx] = issueready;
      operandout       = ent_op[sel_idx];
      wbsout           = ent_wbs[sel_idx];
      flagout          = ent_flag[sel_idx];
      robidout         = ent_rob[sel_idx];
      srcvalsout       = ent_sv[sel_idx];
    end
  end
endmodule
